// File: rtl/quasar_pkg.sv
// ---------------------------------------------------------------------------
// quasar_pkg
// Shared fixed-point types and constants for the qubit simulator datapath.
//   FIXED_WIDTH  : width of one amplitude component / probability word
//   FRAC_DEFAULT : default number of fractional bits (1.0 = 2^FRAC_DEFAULT)
//   amp_t        : signed amplitude component
//   prob_t       : unsigned probability in the same Q format
//   ONE_FIXED    : 1.0 in the default Q format
//   meas_state_t : measurement controller states
// No ports (package).
// ---------------------------------------------------------------------------
package quasar_pkg;

   localparam int FIXED_WIDTH  = 16;
   localparam int FRAC_DEFAULT = FIXED_WIDTH - 2;

   typedef logic signed [FIXED_WIDTH-1:0] amp_t;
   typedef logic        [FIXED_WIDTH-1:0] prob_t;

   localparam prob_t ONE_FIXED = prob_t'(1 << FRAC_DEFAULT);

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      DRAIN,
      DECIDE,
      DONE
   } meas_state_t;

endpackage

// File: rtl/amp_mag_sq.sv
// ---------------------------------------------------------------------------
// amp_mag_sq
// Registered squared magnitude of one complex fixed-point amplitude,
// rescaled back to the amplitude Q format by truncating FRAC fraction bits.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   i_valid   : input amplitude is valid this cycle
//   i_real    : signed real part
//   i_imag    : signed imaginary part
//   o_valid   : o_magSq holds a fresh result (one cycle after i_valid)
//   o_magSq   : (re^2 + im^2) >> FRAC, unsigned
// ---------------------------------------------------------------------------
module amp_mag_sq
   import quasar_pkg::*;
#(
   parameter  int W     = FIXED_WIDTH,
   parameter  int FRAC  = FRAC_DEFAULT,
   localparam int OUT_W = 2*W + 1 - FRAC
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic signed [W-1:0] i_real,
   input  logic signed [W-1:0] i_imag,
   output logic                o_valid,
   output logic [OUT_W-1:0]    o_magSq
);

   logic signed [2*W-1:0] w_re2;
   logic signed [2*W-1:0] w_im2;
   logic        [2*W:0]   w_full;

   // Each square is non-negative and at most 2^(2W-2), so zero-extending
   // both before the add gives the exact unsigned sum in 2W+1 bits.
   assign w_re2  = i_real * i_real;
   assign w_im2  = i_imag * i_imag;
   assign w_full = {1'b0, w_re2} + {1'b0, w_im2};

   // The result register only loads on a valid beat so it holds steady
   // between beats; the valid flag follows the input by exactly one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_magSq <= '0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) begin
            o_magSq <= OUT_W'(w_full >> FRAC);
         end
      end
   end

endmodule

// File: rtl/qubit_measure.sv
// ---------------------------------------------------------------------------
// qubit_measure
// Streams a 2^N_QUBITS complex state vector, accumulates P0 (probability
// that the target qubit is 0) and collapses it against a random threshold.
// Optional feature macro: QUBIT_MEASURE_NORM_CHECK_EN adds a second
// accumulator for the 1-subspace and a sticky norm_err output.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle start pulse, accepted in IDLE only
//   target, threshold     : qubit index and threshold, sampled on start
//   amp_valid/amp_ready   : amplitude stream handshake
//   amp_real/amp_imag     : amplitude components
//   amp_last              : final beat marker
//   res_valid/res_ready   : result handshake
//   res_outcome/res_prob0 : measured bit and saturated P0
//   busy                  : FSM not idle
//   err_len               : sticky framing error of the current measurement
//   norm_err              : (macro only) sticky normalisation error
// ---------------------------------------------------------------------------
module qubit_measure
   import quasar_pkg::*;
#(
   parameter  int N_QUBITS  = 4,
   parameter  int FRAC_BITS = FRAC_DEFAULT,
   localparam int TW        = (N_QUBITS > 1) ? $clog2(N_QUBITS) : 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [TW-1:0] target,
   input  prob_t         threshold,
   input  logic          amp_valid,
   output logic          amp_ready,
   input  amp_t          amp_real,
   input  amp_t          amp_imag,
   input  logic          amp_last,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_outcome,
   output prob_t         res_prob0,
   output logic          busy,
   output logic          err_len
`ifdef QUBIT_MEASURE_NORM_CHECK_EN
  ,output logic          norm_err
`endif
);

   localparam int                  ACC_W    = FIXED_WIDTH + N_QUBITS + 1;
   localparam int                  SQ_W     = 2*FIXED_WIDTH + 1 - FRAC_BITS;
   localparam logic [N_QUBITS-1:0] IDX_LAST = '1;
   localparam logic [ACC_W-1:0]    ONE_ACC  = ACC_W'(1) << FRAC_BITS;
   localparam prob_t               ONE      = prob_t'(ONE_ACC);

   meas_state_t         r_state;
   meas_state_t         w_nextState;
   logic [N_QUBITS-1:0] r_idx;
   logic [TW-1:0]       r_target;
   prob_t               r_thr;
   logic [ACC_W-1:0]    r_acc0;
   logic                r_tagZero;
   logic                r_outcome;
   prob_t               r_prob0;
   logic                r_errLen;
   logic                w_sqValid;
   logic [SQ_W-1:0]     w_sq;
   logic                w_startAcc;
   logic                w_beat;
   logic                w_atLastIdx;
   logic                w_streamEnd;
   prob_t               w_prob0;

   assign w_startAcc  = start && (r_state == IDLE);
   assign w_beat      = amp_valid && amp_ready;
   assign w_atLastIdx = (r_idx == IDX_LAST);
   assign w_streamEnd = w_beat && (amp_last || w_atLastIdx);
   assign w_prob0     = (r_acc0 > ONE_ACC) ? ONE : prob_t'(r_acc0);

   assign res_outcome = r_outcome;
   assign res_prob0   = r_prob0;
   assign err_len     = r_errLen;

   // Stage 1 of the datapath: squared magnitude of each accepted beat.
   amp_mag_sq #(
      .W    (FIXED_WIDTH),
      .FRAC (FRAC_BITS)
   ) u_magSq (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_beat),
      .i_real  (amp_real),
      .i_imag  (amp_imag),
      .o_valid (w_sqValid),
      .o_magSq (w_sq)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next state. Any of the three framing outcomes ends the stream;
   // DRAIN gives the last squared beat one cycle to reach the accumulator.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = ACCUM;
         ACCUM:   if (w_streamEnd) w_nextState = DRAIN;
         DRAIN:   w_nextState = DECIDE;
         DECIDE:  w_nextState = DONE;
         DONE:    if (res_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // FSM outputs, all pure decodes of the current state.
   always_comb begin
      amp_ready = (r_state == ACCUM);
      busy      = (r_state != IDLE);
      res_valid = (r_state == DONE);
   end

   // Measurement context: index counter, sampled target/threshold and the
   // framing flag. A framing error is any last-marker that disagrees with
   // the index being the final one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx    <= '0;
         r_target <= '0;
         r_thr    <= '0;
         r_errLen <= 1'b0;
      end else if (w_startAcc) begin
         r_idx    <= '0;
         r_target <= target;
         r_thr    <= threshold;
         r_errLen <= 1'b0;
      end else if (w_beat) begin
         r_idx <= r_idx + 1'b1;
         if (amp_last != w_atLastIdx) begin
            r_errLen <= 1'b1;
         end
      end
   end

   // Subspace tag travels alongside the stage-1 register so stage 2 knows
   // which sum the registered square belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tagZero <= 1'b0;
      end else if (w_beat) begin
         r_tagZero <= ~r_idx[r_target];
      end
   end

   // Stage 2: P0 accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc0 <= '0;
      end else if (w_startAcc) begin
         r_acc0 <= '0;
      end else if (w_sqValid && r_tagZero) begin
         r_acc0 <= r_acc0 + ACC_W'(w_sq);
      end
   end

   // Result registers, loaded once in DECIDE and held through DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outcome <= 1'b0;
         r_prob0   <= '0;
      end else if (r_state == DECIDE) begin
         r_prob0   <= w_prob0;
         r_outcome <= !(r_thr < w_prob0);
      end
   end

`ifdef QUBIT_MEASURE_NORM_CHECK_EN
   localparam logic [ACC_W:0] ONE_SUM = {1'b0, ONE_ACC};
   localparam logic [ACC_W:0] NORM_TOL = (ACC_W+1)'(1) << (FRAC_BITS - 6);

   logic [ACC_W-1:0] r_acc1;
   logic             r_normErr;
   logic [ACC_W:0]   w_normSum;
   logic [ACC_W:0]   w_normDiff;

   assign w_normSum  = {1'b0, r_acc0} + {1'b0, r_acc1};
   assign w_normDiff = (w_normSum >= ONE_SUM) ? (w_normSum - ONE_SUM)
                                              : (ONE_SUM - w_normSum);
   assign norm_err   = r_normErr;

   // Companion accumulator for the 1-subspace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc1 <= '0;
      end else if (w_startAcc) begin
         r_acc1 <= '0;
      end else if (w_sqValid && !r_tagZero) begin
         r_acc1 <= r_acc1 + ACC_W'(w_sq);
      end
   end

   // Sticky flag when the total probability drifts more than 1/64 from 1.0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_normErr <= 1'b0;
      end else if (w_startAcc) begin
         r_normErr <= 1'b0;
      end else if ((r_state == DECIDE) && (w_normDiff > NORM_TOL)) begin
         r_normErr <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_qubit_measure.sv
// ---------------------------------------------------------------------------
// tb_qubit_measure
// Directed bench for qubit_measure with N_QUBITS=2, FIXED_WIDTH=16,
// FRAC_BITS=14 (1.0 = 16384). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_qubit_measure;
   import quasar_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [0:0]  target;
   prob_t       threshold;
   logic        amp_valid;
   logic        amp_ready;
   amp_t        amp_real;
   amp_t        amp_imag;
   logic        amp_last;
   logic        res_valid;
   logic        res_ready;
   logic        res_outcome;
   prob_t       res_prob0;
   logic        busy;
   logic        err_len;
`ifdef QUBIT_MEASURE_NORM_CHECK_EN
   logic        norm_err;
`endif

   int testsRun  = 0;
   int failCount = 0;
   int cycles;

   amp_t ampRe [4];
   amp_t ampIm [4];

   qubit_measure #(
      .N_QUBITS  (2),
      .FRAC_BITS (14)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .target      (target),
      .threshold   (threshold),
      .amp_valid   (amp_valid),
      .amp_ready   (amp_ready),
      .amp_real    (amp_real),
      .amp_imag    (amp_imag),
      .amp_last    (amp_last),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_outcome (res_outcome),
      .res_prob0   (res_prob0),
      .busy        (busy),
      .err_len     (err_len)
`ifdef QUBIT_MEASURE_NORM_CHECK_EN
     ,.norm_err    (norm_err)
`endif
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Zero the whole state vector before each directed case.
   task automatic clearAmps();
      for (int i = 0; i < 4; i++) begin
         ampRe[i] = '0;
         ampIm[i] = '0;
      end
   endtask

   // Start one measurement and stream the vector. lastAt is the beat that
   // carries amp_last (out of range for none); gap inserts an idle cycle
   // between beats. Returns the number of edges from start to res_valid.
   task automatic applyStimulus(input logic tgt, input int thr, input int lastAt,
                                input int numBeats, input bit gap,
                                output int cyc);
      int   beat;
      int   phase;
      logic take;
      @(posedge clk); #1;
      start     = 1'b1;
      target    = tgt;
      threshold = prob_t'(thr);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busyAfterStart", busy, 1);
      checkOutput("errClearOnStart", err_len, 0);
      beat  = 0;
      phase = 0;
      cyc   = 1;
      while (!res_valid && cyc < 60) begin
         if (beat < numBeats && (!gap || (phase % 2 == 0))) begin
            amp_valid = 1'b1;
            amp_real  = ampRe[beat];
            amp_imag  = ampIm[beat];
            amp_last  = (beat == lastAt);
         end else begin
            amp_valid = 1'b0;
            amp_last  = 1'b0;
            amp_real  = '0;
            amp_imag  = '0;
         end
         take = amp_valid && amp_ready;
         @(posedge clk); #1;
         cyc++;
         phase++;
         if (take) beat++;
      end
      amp_valid = 1'b0;
      amp_last  = 1'b0;
      checkOutput("resValid", res_valid, 1);
   endtask

   // One-cycle result handshake; FSM must be back in IDLE right after.
   task automatic acceptResult();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checkOutput("resValidDrop", res_valid, 0);
      checkOutput("busyIdle", busy, 0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      target    = '0;
      threshold = '0;
      amp_valid = 1'b0;
      amp_real  = '0;
      amp_imag  = '0;
      amp_last  = 1'b0;
      res_ready = 1'b0;
      clearAmps();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstAmpReady", amp_ready, 0);
      checkOutput("rstResValid", res_valid, 0);
      checkOutput("rstProb0", res_prob0, 0);
      checkOutput("rstErrLen", err_len, 0);
      rst = 1'b0;

      // Basis state |00>, target 0: P0 = 1.0, minimum latency.
      clearAmps();
      ampRe[0] = 16384;
      applyStimulus(1'b0, 8192, 3, 4, 1'b0, cycles);
      checkOutput("basisLatency", cycles, 7);
      checkOutput("basisProb0", res_prob0, 16384);
      checkOutput("basisOutcome", res_outcome, 0);
      checkOutput("basisErrLen", err_len, 0);
      acceptResult();

      // Equal superposition on qubit 0: 11585^2 >> 14 = 8191.
      clearAmps();
      ampRe[0] = 11585;
      ampRe[1] = 11585;
      applyStimulus(1'b0, 8000, 3, 4, 1'b0, cycles);
      checkOutput("superProb0", res_prob0, 8191);
      checkOutput("superOutcomeLo", res_outcome, 0);
      acceptResult();
      applyStimulus(1'b0, 9000, 3, 4, 1'b0, cycles);
      checkOutput("superOutcomeHi", res_outcome, 1);
      acceptResult();

      // Pure imaginary amplitude at index 2, target 1: P0 = 0, threshold 0.
      clearAmps();
      ampIm[2] = -16384;
      applyStimulus(1'b1, 0, 3, 4, 1'b0, cycles);
      checkOutput("imagProb0", res_prob0, 0);
      checkOutput("imagOutcome", res_outcome, 1);
      acceptResult();

      // Early amp_last on index 2: indices 0 and 2 contribute 4096 each.
      clearAmps();
      ampRe[0] = 8192;
      ampIm[2] = 8192;
      applyStimulus(1'b0, 10000, 2, 3, 1'b0, cycles);
      checkOutput("earlyLatency", cycles, 6);
      checkOutput("earlyErrLen", err_len, 1);
      checkOutput("earlyProb0", res_prob0, 8192);
      checkOutput("earlyOutcome", res_outcome, 1);
      acceptResult();
      checkOutput("errLenSticky", err_len, 1);

      // Missing amp_last, and P0 above 1.0 saturates; threshold 1.0 -> 1.
      clearAmps();
      ampRe[0] = 16384;
      ampIm[0] = 16384;
      applyStimulus(1'b0, 16384, 99, 4, 1'b0, cycles);
      checkOutput("noLastErrLen", err_len, 1);
      checkOutput("satProb0", res_prob0, ONE_FIXED);
      checkOutput("satOutcome", res_outcome, 1);
      acceptResult();

      // Backpressure on both sides, plus a start while in DONE.
      clearAmps();
      ampRe[0] = 11585;
      ampRe[1] = 11585;
      applyStimulus(1'b0, 8000, 3, 4, 1'b1, cycles);
      checkOutput("gapLatency", cycles, 10);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         @(posedge clk); #1;
         start = 1'b0;
         checkOutput("holdValid", res_valid, 1);
         checkOutput("holdProb0", res_prob0, 8191);
         checkOutput("holdOutcome", res_outcome, 0);
         checkOutput("holdAmpReady", amp_ready, 0);
      end
      acceptResult();

      // Reset in the middle of ACCUM abandons the measurement.
      clearAmps();
      @(posedge clk); #1;
      start     = 1'b1;
      target    = 1'b0;
      threshold = 16'd100;
      @(posedge clk); #1;
      start     = 1'b0;
      amp_valid = 1'b1;
      amp_real  = 16384;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstAmpReady", amp_ready, 0);
      checkOutput("midRstResValid", res_valid, 0);
      checkOutput("midRstProb0", res_prob0, 0);
      checkOutput("midRstOutcome", res_outcome, 0);
      checkOutput("midRstErrLen", err_len, 0);
      amp_valid = 1'b0;
      amp_real  = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("postRstNoResult", res_valid, 0);

      // Full measurement after the abandoned one.
      clearAmps();
      ampRe[0] = 16384;
      applyStimulus(1'b0, 8192, 3, 4, 1'b0, cycles);
      checkOutput("againLatency", cycles, 7);
      checkOutput("againProb0", res_prob0, 16384);
      checkOutput("againOutcome", res_outcome, 0);
      acceptResult();

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/qubit_measure.md
Name: qubit_measure

Overview:
- Reader-side counterpart to the single-qubit gate datapath: gates write amplitudes, this block reads them back and collapses one qubit.
- Streams a full 2^N_QUBITS state vector (complex fixed-point, FIXED_WIDTH from include.vh).
- Accumulates P0 = sum of |amp|^2 over basis indices whose target bit is 0.
- Compares P0 against an externally supplied random threshold and returns the measured bit plus P0 over a valid/ready result port.

Parameters:
- N_QUBITS, 4, register width; the stream length is 2^N_QUBITS amplitudes.
- FRAC_BITS, `FIXED_WIDTH-2, fractional bits of the amplitude format; 1.0 = 2^FRAC_BITS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- target  in  $clog2(N_QUBITS) (min 1)  qubit index; sampled on the accepted start.
- threshold  in  FIXED_WIDTH  unsigned probability in the same Q format; sampled on the accepted start.
- amp_valid  in  1  amplitude beat valid.
- amp_ready  out  1  high only in ACCUM.
- amp_real  in  FIXED_WIDTH  signed real part.
- amp_imag  in  FIXED_WIDTH  signed imaginary part.
- amp_last  in  1  marks the final beat, index 2^N_QUBITS-1.
- res_valid  out  1  result valid; held until accepted.
- res_ready  in  1  result consumer ready.
- res_outcome  out  1  measured bit.
- res_prob0  out  FIXED_WIDTH  unsigned P0, saturated to 1.0.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_len  out  1  sticky framing error for the current measurement; cleared on the next accepted start.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; index counter, accumulator and pipeline register cleared. Reset asserted mid-operation abandons the measurement and emits no result.
- IDLE -> ACCUM on start. start is ignored in any other state.
- ACCUM
  - A beat transfers when amp_valid && amp_ready.
  - The index counter (N_QUBITS bits) increments per beat. The target bit of the index selects whether the beat contributes to P0.
  - Stage 1, registered: sq = real*real + imag*imag, full 2*FIXED_WIDTH+1 unsigned, then shifted right by FRAC_BITS (truncate).
  - Stage 2: if the registered beat belongs to the 0-subspace, acc += sq.
  - acc is unsigned, FIXED_WIDTH+N_QUBITS+1 bits, wide enough that it cannot overflow.
  - Latency: 1 pipeline cycle between beat acceptance and accumulation.
- Framing:
  - amp_last on index 2^N-1 is normal.
  - amp_last earlier: err_len set and the stream ends at that beat.
  - Index 2^N-1 without amp_last: err_len set and the stream ends anyway.
  - In all three cases the FSM goes ACCUM -> DRAIN.
- DRAIN: one cycle for stage 2 to complete -> DECIDE.
- DECIDE (1 cycle):
  - prob0 = min(acc, 2^FRAC_BITS).
  - outcome = 0 if threshold < prob0, else 1.
  - Register both and raise res_valid -> DONE.
- DONE: res_valid, res_outcome and res_prob0 held stable until res_ready. Handshake cycle -> IDLE, res_valid drops the next cycle. res_ready while res_valid is low has no effect.
- Minimum cycles from start to res_valid: 2^N + 3, with amp_valid held high.
- threshold = 0 with prob0 = 0 gives outcome 1. threshold >= 1.0 always gives outcome 1.

Optional Feature:
- QUBIT_MEASURE_NORM_CHECK_EN defined:
  - A second accumulator also sums the 1-subspace.
  - In DECIDE, a sticky output norm_err (extra 1-bit port) is set if |P0+P1 - 2^FRAC_BITS| > 2^(FRAC_BITS-6).
  - norm_err is cleared on the next accepted start.
- Undefined: the port and logic are absent; no other change to behaviour.

Decomposition:
- Shared package quasar_pkg:
  - fixed-point typedefs: amp_t signed FIXED_WIDTH, prob_t unsigned FIXED_WIDTH;
  - ONE_FIXED constant;
  - FSM state enum meas_state_t {IDLE, ACCUM, DRAIN, DECIDE, DONE}.
- One natural sub-module: amp_mag_sq (registered |a|^2 with FRAC_BITS shift). It is reusable for probability readout elsewhere.

Test Plan:
All cases use N_QUBITS=2, FIXED_WIDTH=16, FRAC_BITS=14 (1.0 = 16384).
- Basis state |00> = (16384, 0, 0, 0), target 0, threshold 8192 -> res_prob0 = 16384, outcome 0, res_valid at cycle 7 after start.
- Equal superposition on qubit 0: amps 11585 at indices 0 and 1, others 0, target 0 -> res_prob0 ≈ 8191.
  - threshold 8000 -> outcome 0.
  - threshold 9000 -> outcome 1.
- Imaginary amplitude (0, -16384) at index 2, target 1 -> res_prob0 = 0, outcome 1 for threshold 0.
- Early amp_last on beat 2 -> err_len = 1, a result is still produced, and the next start clears err_len.
- Backpressure: amp_valid toggled every other cycle and res_ready held low 5 cycles -> res_valid and result stable throughout; single handshake returns FSM to IDLE; a start during DONE is ignored.
- rst asserted mid-ACCUM -> immediate IDLE, all outputs 0, no res_valid; the following full measurement is correct.
